// File: rtl/fclass_pkg.sv
// Shared definitions for the FCLASS pipeline: class bit positions, format
// codes, the stage-1 field-flag bundle and the flag-to-mask classifier.
package fclass_pkg;

  localparam int NUM_CLASSES = 10;

  localparam int CLS_NINF  = 0;
  localparam int CLS_NNORM = 1;
  localparam int CLS_NSUB  = 2;
  localparam int CLS_NZERO = 3;
  localparam int CLS_PZERO = 4;
  localparam int CLS_PSUB  = 5;
  localparam int CLS_PNORM = 6;
  localparam int CLS_PINF  = 7;
  localparam int CLS_SNAN  = 8;
  localparam int CLS_QNAN  = 9;

  localparam logic FMT_S = 1'b0;
  localparam logic FMT_D = 1'b1;

  typedef logic [NUM_CLASSES-1:0] class_mask_t;

  // Format-independent summary of an FP operand; enough to pick its class.
  typedef struct packed {
    logic sign;
    logic exp_zero;
    logic exp_ones;
    logic frac_zero;
    logic frac_msb;
  } field_flags_t;

  // Turns the field flags into the one-hot class mask. A box error forces the
  // canonical quiet NaN regardless of the flags.
  function automatic class_mask_t class_onehot(input field_flags_t f, input logic boxerr);
    int idx;
    if (boxerr) begin
      idx = CLS_QNAN;
    end else if (f.exp_ones) begin
      if (f.frac_zero) idx = f.sign ? CLS_NINF : CLS_PINF;
      else             idx = f.frac_msb ? CLS_QNAN : CLS_SNAN;
    end else if (f.exp_zero) begin
      if (f.frac_zero) idx = f.sign ? CLS_NZERO : CLS_PZERO;
      else             idx = f.sign ? CLS_NSUB : CLS_PSUB;
    end else begin
      idx = f.sign ? CLS_NNORM : CLS_PNORM;
    end
    return class_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/fclass_fields.sv
// Splits one IEEE-754 value into the flags the classifier needs.
module fclass_fields
  import fclass_pkg::*;
#(
  parameter int EXPW  = 8,
  parameter int FRACW = 23
) (
  input  logic [EXPW+FRACW:0] value,
  output field_flags_t        flags
);

  logic [EXPW-1:0]  exp_field;
  logic [FRACW-1:0] frac_field;

  assign exp_field  = value[FRACW +: EXPW];
  assign frac_field = value[FRACW-1:0];

  // Pure field decode; no state.
  always_comb begin
    flags.sign      = value[EXPW+FRACW];
    flags.exp_zero  = (exp_field == '0);
    flags.exp_ones  = (exp_field == '1);
    flags.frac_zero = (frac_field == '0);
    flags.frac_msb  = frac_field[FRACW-1];
  end

endmodule

// File: rtl/fclass_pipe.sv
// Two-stage FCLASS pipeline: stage 1 captures the format-muxed field flags,
// stage 2 captures the one-hot class mask. Valid/ready on both sides.
module fclass_pipe
  import fclass_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int FLEN = 64,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_fmt,
  input  logic [FLEN-1:0] in_operand,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_class,
  output logic [TAGW-1:0] out_tag,
  output logic            out_boxerr
);

  field_flags_t flags_s;
  field_flags_t flags_d;
  field_flags_t flags_in;
  logic         boxerr_in;

  logic         v1;
  field_flags_t s1_flags;
  logic         s1_boxerr;
  logic [TAGW-1:0] s1_tag;

  logic         v2;
  class_mask_t  s2_class;
  logic         s2_boxerr;
  logic [TAGW-1:0] s2_tag;

  logic adv1;
  logic adv2;

  fclass_fields #(.EXPW(8), .FRACW(23)) u_fields_s (
    .value (in_operand[31:0]),
    .flags (flags_s)
  );

  fclass_fields #(.EXPW(11), .FRACW(52)) u_fields_d (
    .value (in_operand[63:0]),
    .flags (flags_d)
  );

  // A stage moves when it is empty or its successor is moving; in_ready is
  // therefore a function of out_ready and the valid bits only.
  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  // Select the flag set for the operand's format; singles also need NaN-boxing.
  always_comb begin
    flags_in  = flags_d;
    boxerr_in = 1'b0;
    if (in_fmt == FMT_S) begin
      flags_in  = flags_s;
      boxerr_in = !(&in_operand[63:32]);
    end
  end

  // Stage 1: capture flags, box error and tag on every accepted operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1_flags  <= '0;
      s1_boxerr <= 1'b0;
      s1_tag    <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_flags  <= flags_in;
        s1_boxerr <= boxerr_in;
        s1_tag    <= in_tag;
      end
    end
  end

  // Stage 2: classify the stage-1 flags and hold the result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      s2_class  <= '0;
      s2_boxerr <= 1'b0;
      s2_tag    <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s2_class  <= class_onehot(s1_flags, s1_boxerr);
        s2_boxerr <= s1_boxerr;
        s2_tag    <= s1_tag;
      end
    end
  end

  assign out_valid  = v2;
  assign out_class  = {{(XLEN-NUM_CLASSES){1'b0}}, s2_class};
  assign out_tag    = s2_tag;
  assign out_boxerr = s2_boxerr;

endmodule

// File: tb/tb_fclass_pipe.sv
// Self-checking bench for fclass_pipe: directed cases with literal results,
// then a class sweep and a randomized stream checked against a queue model.
module tb_fclass_pipe;

  localparam int XLEN = 32;
  localparam int FLEN = 64;
  localparam int TAGW = 5;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_fmt;
  logic [FLEN-1:0] in_operand;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_class;
  logic [TAGW-1:0] out_tag;
  logic            out_boxerr;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [31:0] cls;
    logic [4:0]  tag;
    logic        boxerr;
    logic        fmt;
    int          edge_no;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] emitted_tags[$];
  int         class_hits[2][10];

  fclass_pipe #(.XLEN(XLEN), .FLEN(FLEN), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_operand (in_operand),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_tag    (out_tag),
    .out_boxerr (out_boxerr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h (cycle %0d)", name, got, want, cycle);
    end
  endtask

  // Reference classifier straight from the IEEE-754 field rules.
  function automatic int model_class(input logic fmt, input logic [63:0] op, output logic boxerr);
    logic [63:0] e;
    logic [63:0] f;
    logic [63:0] emax;
    logic        sign;
    logic        quiet;
    boxerr = 1'b0;
    if (fmt == 1'b0) begin
      if (op[63:32] != 32'hFFFF_FFFF) begin
        boxerr = 1'b1;
        return 9;
      end
      sign  = op[31];
      e     = 64'(op[30:23]);
      f     = 64'(op[22:0]);
      emax  = 64'd255;
      quiet = op[22];
    end else begin
      sign  = op[63];
      e     = 64'(op[62:52]);
      f     = 64'(op[51:0]);
      emax  = 64'd2047;
      quiet = op[51];
    end
    if (e == emax) begin
      if (f == 64'd0) return sign ? 0 : 7;
      return quiet ? 9 : 8;
    end
    if (e == 64'd0) begin
      if (f == 64'd0) return sign ? 3 : 4;
      return sign ? 2 : 5;
    end
    return sign ? 1 : 6;
  endfunction

  // Builds a random operand of the requested class (10 = anything, 11 = unboxed single).
  function automatic logic [63:0] make_operand(input logic fmt, input int cls);
    int          ew;
    int          fw;
    logic [63:0] e;
    logic [63:0] f;
    logic [63:0] emax;
    logic [63:0] sign;
    logic [63:0] r;
    ew   = fmt ? 11 : 8;
    fw   = fmt ? 52 : 23;
    emax = (64'd1 << ew) - 64'd1;
    f    = {$urandom, $urandom} & ((64'd1 << fw) - 64'd1);
    sign = ($urandom_range(0, 1) == 1) ? 64'd1 : 64'd0;
    e    = 64'($urandom_range(1, 32'(emax) - 1));
    case (cls)
      0, 7: begin e = emax; f = 64'd0; sign = (cls == 0) ? 64'd1 : 64'd0; end
      1, 6: sign = (cls == 1) ? 64'd1 : 64'd0;
      2, 5: begin
        e = 64'd0;
        if (f == 64'd0) f = 64'd1;
        sign = (cls == 2) ? 64'd1 : 64'd0;
      end
      3, 4: begin e = 64'd0; f = 64'd0; sign = (cls == 3) ? 64'd1 : 64'd0; end
      8: begin
        e = emax;
        f = f & ~(64'd1 << (fw - 1));
        if (f == 64'd0) f = 64'd1;
      end
      9: begin e = emax; f = f | (64'd1 << (fw - 1)); end
      default: ;
    endcase
    r = (sign << (ew + fw)) | (e << fw) | f;
    if (!fmt) r[63:32] = 32'hFFFF_FFFF;
    if (cls == 10) begin
      r = {$urandom, $urandom};
      if (!fmt && ($urandom_range(0, 1) == 1)) r[63:32] = 32'hFFFF_FFFF;
    end
    if (cls == 11) r[63:32] = $urandom & 32'hFFFF_FFFE;
    return r;
  endfunction

  // Model: every accepted operand joins the queue with its expected result and
  // the edge it was accepted on; every emitted result retires the oldest entry.
  always @(posedge clk or negedge rst_n) begin
    exp_t ent;
    int   c;
    logic be;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      cycle++;
      if (out_valid && out_ready && (exp_q.size() > 0)) begin
        emitted_tags.push_back(out_tag);
        for (int i = 0; i < 10; i++)
          if (out_class[i]) class_hits[exp_q[0].fmt][i]++;
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        c           = model_class(in_fmt, in_operand, be);
        ent.cls     = 32'd1 << c;
        ent.tag     = in_tag;
        ent.boxerr  = be;
        ent.fmt     = in_fmt;
        ent.edge_no = cycle;
        exp_q.push_back(ent);
      end
    end
  end

  // Compare process: the oldest entry must be on the outputs from the edge
  // after its acceptance; ready is high unless two results are held and stalled.
  always @(negedge clk) begin
    logic exp_v;
    logic exp_rdy;
    if (rst_n) begin
      exp_v   = (exp_q.size() > 0) && (cycle > exp_q[0].edge_no);
      exp_rdy = (exp_q.size() < 2) || out_ready;
      checkOutput("out_valid", 64'(out_valid), 64'(exp_v));
      checkOutput("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (out_valid && exp_v) begin
        checkOutput("out_class", 64'(out_class), 64'(exp_q[0].cls));
        checkOutput("out_tag", 64'(out_tag), 64'(exp_q[0].tag));
        checkOutput("out_boxerr", 64'(out_boxerr), 64'(exp_q[0].boxerr));
        checkOutput("onehot", 64'($countones(out_class)), 64'd1);
        checkOutput("upper_zero", 64'(out_class[31:10]), 64'd0);
      end
    end
  end

  task automatic applyStimulus(input logic fmt, input logic [63:0] op, input logic [4:0] tag);
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    in_fmt     = fmt;
    in_operand = op;
    in_tag     = tag;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_q.size() > 0) && (n < 50)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic be;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_fmt     = 1'b0;
    in_operand = '0;
    in_tag     = '0;
    out_ready  = 1'b1;

    // Model pins against hand-computed classes.
    checkOutput("model_ninf_s", 64'(model_class(1'b0, 64'hFFFFFFFF_FF800000, be)), 64'd0);
    checkOutput("model_box_s", 64'(model_class(1'b0, 64'h00000000_3F800000, be)), 64'd9);
    checkOutput("model_boxerr_s", 64'(be), 64'd1);
    checkOutput("model_snan_d", 64'(model_class(1'b1, 64'h7FF00000_00000001, be)), 64'd8);
    checkOutput("model_psub_d", 64'(model_class(1'b1, 64'h00000000_00000001, be)), 64'd5);

    // Reset state.
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_class", 64'(out_class), 64'd0);
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
    checkOutput("rst_out_boxerr", 64'(out_boxerr), 64'd0);
    #7;
    rst_n = 1'b1;

    // Boxed single -inf.
    applyStimulus(1'b0, 64'hFFFFFFFF_FF800000, 5'd7);
    idleCycle();
    idleCycle();
    checkOutput("s_ninf_class", 64'(out_class), 64'h001);
    checkOutput("s_ninf_boxerr", 64'(out_boxerr), 64'd0);
    checkOutput("s_ninf_tag", 64'(out_tag), 64'd7);

    // Unboxed single, then the same value boxed.
    applyStimulus(1'b0, 64'h00000000_3F800000, 5'd2);
    idleCycle();
    idleCycle();
    checkOutput("s_unboxed_class", 64'(out_class), 64'h200);
    checkOutput("s_unboxed_boxerr", 64'(out_boxerr), 64'd1);
    applyStimulus(1'b0, 64'hFFFFFFFF_3F800000, 5'd3);
    idleCycle();
    idleCycle();
    checkOutput("s_boxed_class", 64'(out_class), 64'h040);
    checkOutput("s_boxed_boxerr", 64'(out_boxerr), 64'd0);

    // Three back-to-back doubles.
    applyStimulus(1'b1, 64'h7FF00000_00000001, 5'd10);
    applyStimulus(1'b1, 64'h80000000_00000000, 5'd11);
    applyStimulus(1'b1, 64'h00000000_00000001, 5'd12);
    checkOutput("b2b_a_class", 64'(out_class), 64'h100);
    checkOutput("b2b_a_tag", 64'(out_tag), 64'd10);
    idleCycle();
    checkOutput("b2b_b_class", 64'(out_class), 64'h008);
    checkOutput("b2b_b_tag", 64'(out_tag), 64'd11);
    idleCycle();
    checkOutput("b2b_c_class", 64'(out_class), 64'h020);
    checkOutput("b2b_c_tag", 64'(out_tag), 64'd12);
    idleCycle();
    waitDrain();

    // Backpressure: two operands fill the pipe, the rest wait.
    out_ready = 1'b0;
    emitted_tags.delete();
    applyStimulus(1'b1, 64'h3FF00000_00000000, 5'd1);
    applyStimulus(1'b1, 64'h3FF00000_00000000, 5'd2);
    applyStimulus(1'b1, 64'h3FF00000_00000000, 5'd3);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_out_tag", 64'(out_tag), 64'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_tag", 64'(out_tag), 64'd1);
      checkOutput("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    applyStimulus(1'b1, 64'h3FF00000_00000000, 5'd4);
    idleCycle();
    waitDrain();
    checkOutput("bp_count", 64'(emitted_tags.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < emitted_tags.size())
        checkOutput("bp_order", 64'(emitted_tags[i]), 64'(i + 1));

    // Reset with both stages occupied.
    out_ready = 1'b0;
    applyStimulus(1'b1, 64'hBFF00000_00000000, 5'd5);
    applyStimulus(1'b1, 64'hBFF00000_00000000, 5'd6);
    idleCycle();
    checkOutput("mid_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_out_class", 64'(out_class), 64'd0);
    checkOutput("mid_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("post_rst_valid", 64'(out_valid), 64'd0);
      checkOutput("post_rst_ready", 64'(in_ready), 64'd1);
    end

    // Sweep every class in both formats, plus an unboxed single.
    for (int fmt = 0; fmt < 2; fmt++)
      for (int c = 0; c < 10; c++)
        applyStimulus(fmt[0], make_operand(fmt[0], c), 5'(c));
    applyStimulus(1'b0, make_operand(1'b0, 11), 5'd31);
    idleCycle();
    waitDrain();

    // Randomized stream with random backpressure.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      in_valid   = ($urandom_range(0, 3) != 0);
      in_fmt     = $urandom_range(0, 1) == 1;
      in_operand = make_operand(in_fmt, int'($urandom_range(0, 11)));
      in_tag     = 5'($urandom);
      out_ready  = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitDrain();

    for (int fmt = 0; fmt < 2; fmt++)
      for (int c = 0; c < 10; c++)
        checkOutput("class_seen", 64'(class_hits[fmt][c] > 0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
